// File: rtl/mux_arb_pkg.sv
// Shared constants for the two-source round-robin mux arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mux_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Source indices double as the mux select value for that source.
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux2_bus.sv
// DATA_W-wide 2:1 mux built from one two_way_mux per bit.
// Latency: combinational.
// Backpressure: n/a.
module mux2_bus #(
  parameter int DATA_W = 8
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    two_way_mux u_mux (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .sel_i (sel_i),
      .y_o   (y_o[i])
    );
  end

endmodule : mux2_bus

// File: rtl/two_way_mux.sv
// 1-bit 2:1 multiplexer primitive: y = sel ? b : a.
// Latency: combinational.
// Backpressure: n/a.
module two_way_mux (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule : two_way_mux

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two valid/ready sources feeding one registered output.
// Latency: payload accepted in cycle T is on out_data with out_valid=1 in T+1.
// Backpressure: full output with out_ready=0 deasserts both readies; output holds.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              sel,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic              ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              can_load;
  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] mux_dat;

  // Output register can take a new payload when empty or being drained this cycle.
  assign can_load = ~out_valid_q | out_ready;

  // Grant: pointer breaks ties; a lone requester wins; idle keeps select on ptr.
  always_comb begin
    grant = ptr_q;
    if (req0_valid && req1_valid) begin
      grant = ptr_q;
    end else if (req0_valid) begin
      grant = SRC0;
    end else if (req1_valid) begin
      grant = SRC1;
    end
  end

  // Reset forces select low and blocks both handshakes.
  assign sel        = rst ? SRC0 : grant;
  assign req0_ready = ~rst & can_load & req0_valid & (grant == SRC0);
  assign req1_ready = ~rst & can_load & req1_valid & (grant == SRC1);
  assign accept     = req0_ready | req1_ready;

  mux2_bus #(
    .DATA_W (DATA_W)
  ) u_bus (
    .sel_i (sel),
    .a_i   (req0_data),
    .b_i   (req1_data),
    .y_o   (mux_dat)
  );

  // Next state: load on accept, otherwise drain if consumed; counters saturate.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_dat;
      out_src_d   = grant;
      ptr_d       = ~grant;
      if (grant == SRC0) begin
        if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
      end else begin
        if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
      end
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously so in-flight data is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= SRC0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule : mux2_rr_arbiter
